// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and port ids for the two-port memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    function automatic logic other_port(input logic port_id);
        return ~port_id;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way winner select with a priority tie-break
import mem_arb_pkg::*;

module rr_pick2 (
    input  logic a_req,
    input  logic b_req,
    input  logic prio,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = a_req | b_req;
        grant_id    = PORT_A;
        if (a_req && b_req) begin
            grant_id = prio;
        end else if (b_req) begin
            grant_id = PORT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter_2.sv
// rtl/mem_arbiter_2.sv - round-robin arbiter sharing one register memory between ports A and B
import mem_arb_pkg::*;

module mem_arbiter_2 #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic                  a_lock,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [WIDTH-1:0]      a_wdata,
    output logic                  a_ack,
    output logic [WIDTH-1:0]      a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic                  b_lock,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [WIDTH-1:0]      b_wdata,
    output logic                  b_ack,
    output logic [WIDTH-1:0]      b_rdata,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_idata,
    input  logic [WIDTH-1:0]      mem_odata,
    output logic                  busy
);

    state_t                state;
    state_t                state_nxt;
    logic                  prio;
    logic                  owner;
    logic                  lat_we;
    logic                  lat_lock;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [WIDTH-1:0]      lat_wdata;
    logic [WIDTH-1:0]      rdata_reg;
    logic                  grant_valid;
    logic                  grant_id;

    rr_pick2 u_pick (
        .a_req       (a_req),
        .b_req       (b_req),
        .prio        (prio),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = SERVE;
            SERVE:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= PORT_A;
            owner     <= PORT_A;
            lat_we    <= 1'b0;
            lat_lock  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_reg <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_valid) begin
                owner     <= grant_id;
                lat_we    <= (grant_id == PORT_B) ? b_we    : a_we;
                lat_lock  <= (grant_id == PORT_B) ? b_lock  : a_lock;
                lat_addr  <= (grant_id == PORT_B) ? b_addr  : a_addr;
                lat_wdata <= (grant_id == PORT_B) ? b_wdata : a_wdata;
            end
            if (state == SERVE) begin
                rdata_reg <= mem_odata;
                prio      <= lat_lock ? owner : other_port(owner);
            end
        end
    end

    // The latches double as the memory bus so addr/idata hold between transactions.
    // A reset during SERVE suppresses the write so the dropped transaction leaves no trace.
    always_comb begin
        mem_addr  = lat_addr;
        mem_idata = lat_wdata;
        mem_write = (state == SERVE) && lat_we && !rst;
        busy      = (state == SERVE) || (state == ACK);
        a_ack     = (state == ACK) && (owner == PORT_A);
        b_ack     = (state == ACK) && (owner == PORT_B);
        a_rdata   = a_ack ? rdata_reg : '0;
        b_rdata   = b_ack ? rdata_reg : '0;
    end

endmodule

// File: tb/tb_mem_arbiter_2.sv
// tb/tb_mem_arbiter_2.sv - randomized self-checking bench for mem_arbiter_2 against a transaction model
module tb_mem_arbiter_2;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_ack, b_ack, mem_write, busy;
    logic [31:0] a_rdata, b_rdata;
    logic [4:0]  mem_addr;
    logic [31:0] mem_idata, mem_odata;

    logic [31:0] mem_arr [32];
    logic [31:0] ref_mem [32];
    logic        m_prio;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter_2 #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_lock    (a_lock),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_lock    (b_lock),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_idata (mem_idata),
        .mem_odata (mem_odata),
        .busy      (busy)
    );

    assign mem_odata = mem_arr[mem_addr];
    always @(posedge clk) begin
        if (mem_write) mem_arr[mem_addr] <= mem_idata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One arbitration round: each enabled port issues one command and drops req on its ack.
    task automatic round(input logic [1:0] on, input logic [1:0] we, input logic [1:0] lk,
                         input logic [4:0] ad0, input logic [4:0] ad1,
                         input logic [31:0] wd0, input logic [31:0] wd1);
        logic [4:0]  ad [2];
        logic [31:0] wd [2];
        logic [31:0] exp_rd [2];
        int          gcyc [2];
        int          n;
        int          last;
        logic        first;
        logic        sp;
        logic        serving;
        logic        exp_a, exp_b;
        ad[0] = ad0; ad[1] = ad1;
        wd[0] = wd0; wd[1] = wd1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        gcyc[0] = -10; gcyc[1] = -10;
        n = int'(on[0]) + int'(on[1]);
        first = (on == 2'b11) ? m_prio : on[1];
        for (int k = 0; k < n; k++) begin
            logic p;
            p = (k == 0) ? first : ~first;
            gcyc[p] = 1 + 3 * k;
            exp_rd[p] = ref_mem[ad[p]];
            if (we[p]) ref_mem[ad[p]] = wd[p];
            m_prio = lk[p] ? p : ~p;
        end
        a_req = on[0]; a_we = we[0]; a_lock = lk[0]; a_addr = ad0; a_wdata = wd0;
        b_req = on[1]; b_we = we[1]; b_lock = lk[1]; b_addr = ad1; b_wdata = wd1;
        last = (n == 0) ? 2 : 3 * n;
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            exp_a   = (cyc == gcyc[0] + 1);
            exp_b   = (cyc == gcyc[1] + 1);
            serving = (cyc == gcyc[0]) || (cyc == gcyc[1]);
            sp      = (cyc == gcyc[1]);
            check("a_ack", 32'(a_ack), 32'(exp_a));
            check("b_ack", 32'(b_ack), 32'(exp_b));
            check("a_rdata", a_rdata, exp_a ? exp_rd[0] : 32'h0);
            check("b_rdata", b_rdata, exp_b ? exp_rd[1] : 32'h0);
            check("busy", 32'(busy), 32'(serving || exp_a || exp_b));
            check("mem_write", 32'(mem_write), 32'(serving && we[sp]));
            if (serving) begin
                check("mem_addr", 32'(mem_addr), 32'(ad[sp]));
                if (we[sp]) check("mem_idata", mem_idata, wd[sp]);
                if (sp == 1'b0) begin
                    a_addr = 5'($urandom); a_wdata = $urandom; a_we = 1'($urandom); a_lock = 1'($urandom);
                end else begin
                    b_addr = 5'($urandom); b_wdata = $urandom; b_we = 1'($urandom); b_lock = 1'($urandom);
                end
                #1;
                check("mem_addr_hold", 32'(mem_addr), 32'(ad[sp]));
            end
            if (exp_a) a_req = 1'b0;
            if (exp_b) b_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_prio = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_arr[i] = '0;
            ref_mem[i] = '0;
        end
        m_prio = 1'b0;
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = '0; b_wdata = '0;

        // Held reset with a pending request: nothing may happen.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_a_ack", 32'(a_ack), 32'h0);
            check("rst_mem_write", 32'(mem_write), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
        end
        rst = 1'b0;
        round(2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

        // Swap semantics: the write returns the old word, the read returns the new one.
        round(2'b01, 2'b01, 2'b00, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
        round(2'b01, 2'b00, 2'b00, 5'd5, 5'd0, 32'h0, 32'h0);

        // Continuous contention from reset alternates A, B, A, B.
        do_reset();
        a_req = 1'b1; a_we = 1'b0; a_lock = 1'b0; a_addr = 5'd1;
        b_req = 1'b1; b_we = 1'b0; b_lock = 1'b0; b_addr = 5'd2;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            check("cont_a_ack", 32'(a_ack), 32'(cyc == 2 || cyc == 8));
            check("cont_b_ack", 32'(b_ack), 32'(cyc == 5 || cyc == 11));
            if (a_ack) check("cont_a_rdata", a_rdata, ref_mem[1]);
            if (b_ack) check("cont_b_rdata", b_rdata, ref_mem[2]);
            if (cyc == 11) begin a_req = 1'b0; b_req = 1'b0; end
        end
        m_prio = 1'b0;

        // Locked read-modify-write on A keeps B waiting until both A transactions finish.
        a_req = 1'b1; a_we = 1'b0; a_lock = 1'b1; a_addr = 5'd7;
        b_req = 1'b1; b_we = 1'b0; b_lock = 1'b0; b_addr = 5'd7;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            check("lock_a_ack", 32'(a_ack), 32'(cyc == 2 || cyc == 5));
            check("lock_b_ack", 32'(b_ack), 32'(cyc == 8));
            if (cyc == 2) begin
                check("lock_a_rd", a_rdata, ref_mem[7]);
                a_we = 1'b1; a_lock = 1'b0; a_wdata = 32'h1;
            end
            if (cyc == 5) begin
                check("lock_a_wr_old", a_rdata, ref_mem[7]);
                ref_mem[7] = 32'h1;
                a_req = 1'b0;
            end
            if (cyc == 8) begin
                check("lock_b_rd", b_rdata, ref_mem[7]);
                b_req = 1'b0;
            end
        end
        m_prio = 1'b0;

        // Reset during SERVE of a B write drops it entirely.
        do_reset();
        b_req = 1'b1; b_we = 1'b1; b_lock = 1'b0; b_addr = 5'd3; b_wdata = 32'h55;
        @(negedge clk);
        check("mid_mem_write", 32'(mem_write), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_b_ack", 32'(b_ack), 32'h0);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_mem_write_rst", 32'(mem_write), 32'h0);
        rst = 1'b0; b_req = 1'b0; m_prio = 1'b0;
        round(2'b11, 2'b00, 2'b00, 5'd3, 5'd3, 32'h0, 32'h0);

        // Command inputs are scrambled inside round() once granted.
        round(2'b01, 2'b00, 2'b00, 5'd4, 5'd0, 32'h0, 32'h0);

        for (int r = 0; r < 60; r++) begin
            round(2'($urandom), 2'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
                  $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
